aes_req_arbiter: RTL and testbench
==================================

# aes_req_arbiter

Round-robin arbiter and sequencer that shares one `aes128_core` encryption engine among `NUM_REQ` requesters. It accepts one key/plaintext job at a time, issues the core's one-cycle start, waits for the core's done pulse, and returns the ciphertext to the granted requester through a valid/ready response. A watchdog reports a stalled core as an error response. The block sits between requester-side bus adapters and the single core instance.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..16).
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before an error response (1..65535).
- `IDW`, derived, equals `$clog2(NUM_REQ)`: width of the grant index.

- `clk`  in  1: the single clock. All logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ: per-requester job valid.
- `req_key_i`  in  NUM_REQ*128: packed keys. Requester i uses bits [i*128 +: 128].
- `req_pt_i`  in  NUM_REQ*128: packed plaintexts, same packing as `req_key_i`.
- `req_ready_o`  out  NUM_REQ: one-hot job-accept strobe.
- `rsp_valid_o`  out  NUM_REQ: one-hot response valid.
- `rsp_ready_i`  in  NUM_REQ: per-requester response ready.
- `rsp_data_o`  out  128: ciphertext, or 0 on error.
- `rsp_err_o`  out  1: 1 means the core timed out.
- `core_start_o`  out  1: one-cycle start pulse to the core.
- `core_key_o`  out  128: key to the core.
- `core_pt_o`  out  128: plaintext to the core.
- `core_ready_i`  in  1: core is idle.
- `core_done_i`  in  1: core done pulse. Ciphertext is valid in the same cycle.
- `core_ct_i`  in  128: core ciphertext.
- `busy_o`  out  1: high whenever the block is not in IDLE.
- `grant_id_o`  out  IDW: index of the current or last granted requester.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - Arbitration runs only when `core_ready_i` = 1 and at least one `req_valid_i` bit is set.
  - Winner: the first valid index at or after `ptr` = (`last_grant` + 1) mod `NUM_REQ`, searching upward with wrap.
  - `req_ready_o[winner]` is driven combinationally high in that cycle. That cycle is the acceptance handshake.
  - On the next edge: latch key and plaintext into internal registers, set `grant_id_o` to the winner, go to ISSUE.
  - If `core_ready_i` = 0, nothing is accepted and the FSM stays in IDLE.
- **ISSUE**
  - `core_start_o` = 1 for exactly one cycle.
  - `core_key_o` and `core_pt_o` come from the latched registers and hold through WAIT.
  - Clear the watchdog counter. Go to WAIT.
- **WAIT**
  - If `core_done_i` = 1: `rsp_data_o` takes `core_ct_i`, `rsp_err_o` takes 0, go to RESP.
  - Otherwise the counter increments.
  - When the counter equals `TIMEOUT - 1` and `core_done_i` = 0: `rsp_data_o` takes 0, `rsp_err_o` takes 1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- **RESP**
  - `rsp_valid_o[grant_id_o]` = 1. `rsp_data_o` and `rsp_err_o` are held stable.
  - When `rsp_ready_i[grant_id_o]` = 1: `last_grant` takes `grant_id_o`, go to IDLE.
  - Ready bits of other requesters are ignored.
- **Requester rules**
  - Requesters hold `req_valid_i` and their data stable until accepted.
  - Deasserting valid before acceptance withdraws the request. This is legal.
- **Ignored inputs:** `core_done_i` outside WAIT is ignored. A late done that arrives after a timeout is dropped.
- **Reset**
  - `req_ready_o`, `rsp_valid_o`, `rsp_data_o`, `rsp_err_o`, `core_start_o`, `core_key_o`, `core_pt_o`, `busy_o` and `grant_id_o` are all 0. The latched registers and the counter are 0.
  - `last_grant` = `NUM_REQ - 1`, so requester 0 has first priority.
- **Reset mid-operation:** the in-flight job is abandoned and no response is issued. The core is not reset by this block. The next issue waits for `core_ready_i`.

## Timing
- Job accepted at edge T (`req_valid` and `req_ready` both high). `core_start_o` is high in cycle T+1. The FSM is in WAIT from T+2.
- `core_done_i` in cycle D gives `rsp_valid_o` high from D+1.
- Response consumed at edge R means the FSM is in IDLE at R+1. The next acceptance can happen in cycle R+1. Back-to-back overhead is 3 cycles plus core latency.
- Timeout response: `rsp_valid_o` rises `TIMEOUT` + 1 cycles after `core_start_o`.
- `busy_o` is registered and equals (state != IDLE).
- At most one bit of `req_ready_o` and at most one bit of `rsp_valid_o` is set in any cycle.

## Test plan
- **Single request:** `NUM_REQ`=4. Requester 2 sends key 000102…0f and plaintext 00112233…ff. The core model responds with FIPS-197 result 69c4e0d86a7b0430d8cdb78070b4c55a. Expect `core_start_o` for one cycle at T+1, `rsp_valid_o`=0100 with that data and `rsp_err_o`=0.
- **Round-robin fairness:** all four requesters hold valid continuously for 8 jobs. Grant order must be 0,1,2,3,0,1,2,3, with no requester granted twice while another is waiting.
- **Response backpressure:** hold `rsp_ready_i[1]`=0 for 20 cycles and pulse `rsp_ready_i[0]`. The data must stay stable, no new `req_ready_o` may assert, and the transaction completes one cycle after `rsp_ready_i[1]` rises.
- **Timeout:** `TIMEOUT`=10 and the core never returns done. `rsp_err_o`=1 with `rsp_data_o`=0, 11 cycles after start. A later `core_done_i` is ignored.
- **Core not ready:** `core_ready_i`=0 with requests pending. No acceptance and no start until `core_ready_i` rises, then acceptance happens in that cycle.
- **Reset mid-WAIT:** assert `rst` for one cycle. All outputs return to 0 on the next cycle, no response is produced, and the next grant goes to requester 0.

Source files
------------

// File: rtl/aes_req_arbiter.sv
// rtl/aes_req_arbiter.sv - round-robin job arbiter and sequencer sharing one aes128_core
module aes_req_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int TIMEOUT = 255,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   input  logic [NUM_REQ*128-1:0] req_key_i,
   input  logic [NUM_REQ*128-1:0] req_pt_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   output logic [NUM_REQ-1:0]     rsp_valid_o,
   input  logic [NUM_REQ-1:0]     rsp_ready_i,
   output logic [127:0]           rsp_data_o,
   output logic                   rsp_err_o,
   output logic                   core_start_o,
   output logic [127:0]           core_key_o,
   output logic [127:0]           core_pt_o,
   input  logic                   core_ready_i,
   input  logic                   core_done_i,
   input  logic [127:0]           core_ct_i,
   output logic                   busy_o,
   output logic [IDW-1:0]         grant_id_o
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);
   localparam logic [15:0]    TO_LAST  = 16'(TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [IDW-1:0]     last_grant_q, last_grant_d;
   logic [IDW-1:0]     grant_q, grant_d;
   logic [127:0]       key_q, key_d;
   logic [127:0]       pt_q, pt_d;
   logic [127:0]       rsp_data_q, rsp_data_d;
   logic               rsp_err_q, rsp_err_d;
   logic               start_q, start_d;
   logic               busy_q, busy_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [15:0]        cnt_q, cnt_d;

   logic [IDW-1:0]     ptr;
   logic [IDW-1:0]     win_idx;
   logic [IDW-1:0]     cand_idx;
   int                 cand;
   logic               win_found;
   logic               accept;
   logic               rsp_ready_sel;
   logic [NUM_REQ-1:0] grant_oh;
   logic [127:0]       key_sel, pt_sel;

   // Search starts one past the last served requester and wraps, giving round-robin order.
   always_comb begin
      ptr       = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + 1'b1;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = IDW'(cand);
         if (!win_found && req_valid_i[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   assign accept = (state_q == S_IDLE) && !rst && core_ready_i && win_found;

   always_comb begin
      req_ready_o = '0;
      grant_oh    = '0;
      key_sel     = '0;
      pt_sel      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready_o[i] = accept && (win_idx == IDW'(i));
         grant_oh[i]    = (grant_q == IDW'(i));
         if (win_idx == IDW'(i)) begin
            key_sel = req_key_i[i*128 +: 128];
            pt_sel  = req_pt_i[i*128 +: 128];
         end
      end
      rsp_ready_sel = |(rsp_ready_i & grant_oh);
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      key_d        = key_q;
      pt_d         = pt_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      rsp_valid_d  = rsp_valid_q;
      cnt_d        = cnt_q;
      start_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               grant_d = win_idx;
               key_d   = key_sel;
               pt_d    = pt_sel;
               start_d = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A done arriving on the final watchdog cycle still returns the ciphertext.
            if (core_done_i) begin
               rsp_data_d  = core_ct_i;
               rsp_err_d   = 1'b0;
               rsp_valid_d = grant_oh;
               state_d     = S_RESP;
            end else if (cnt_q == TO_LAST) begin
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = grant_oh;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready_sel) begin
               last_grant_d = grant_q;
               rsp_valid_d  = '0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= LAST_IDX;
         grant_q      <= '0;
         key_q        <= '0;
         pt_q         <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         rsp_valid_q  <= '0;
         cnt_q        <= '0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         key_q        <= key_d;
         pt_q         <= pt_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         rsp_valid_q  <= rsp_valid_d;
         cnt_q        <= cnt_d;
         start_q      <= start_d;
         busy_q       <= busy_d;
      end
   end

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_err_o    = rsp_err_q;
   assign core_start_o = start_q;
   assign core_key_o   = key_q;
   assign core_pt_o    = pt_q;
   assign busy_o       = busy_q;
   assign grant_id_o   = grant_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb/tb_aes_req_arbiter.sv - self-checking bench for aes_req_arbiter with a behavioural core and arbiter model
module tb_aes_req_arbiter;
   localparam int N  = 4;
   localparam int TO = 10;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid_i;
   logic [N*128-1:0] req_key_i;
   logic [N*128-1:0] req_pt_i;
   logic [N-1:0]     req_ready_o;
   logic [N-1:0]     rsp_valid_o;
   logic [N-1:0]     rsp_ready_i;
   logic [127:0]     rsp_data_o;
   logic             rsp_err_o;
   logic             core_start_o;
   logic [127:0]     core_key_o;
   logic [127:0]     core_pt_o;
   logic             core_ready_i;
   logic             core_done_i;
   logic [127:0]     core_ct_i;
   logic             busy_o;
   logic [1:0]       grant_id_o;

   logic [127:0]     key_a [N];
   logic [127:0]     pt_a  [N];
   int               n_assert = 0;
   int               n_fail   = 0;
   int               last_m;
   logic             flood;

   always #5 clk = ~clk;

   aes_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_key_i(req_key_i), .req_pt_i(req_pt_i),
      .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .core_start_o(core_start_o), .core_key_o(core_key_o), .core_pt_o(core_pt_o),
      .core_ready_i(core_ready_i), .core_done_i(core_done_i), .core_ct_i(core_ct_i),
      .busy_o(busy_o), .grant_id_o(grant_id_o)
   );

   always_comb begin
      req_key_i = '0;
      req_pt_i  = '0;
      for (int i = 0; i < N; i++) begin
         req_key_i[i*128 +: 128] = key_a[i];
         req_pt_i[i*128 +: 128]  = pt_a[i];
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [N-1:0] oh(input int i);
      return N'(1) << i;
   endfunction

   // Reference: first valid requester strictly after the last one served, wrapping around.
   function automatic int ref_winner(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (((v >> idx) & N'(1)) != '0) return idx;
      end
      return -1;
   endfunction

   task automatic drv_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst         = 1'b1;
      req_valid_i = '1;
      @(negedge clk);
      chk("rst_no_ready", req_ready_o, '0);
      drv_edge();
      rst         = 1'b0;
      req_valid_i = '0;
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid_o, '0);
      chk("rst_rsp_data", rsp_data_o, '0);
      chk("rst_rsp_err", rsp_err_o, '0);
      chk("rst_start", core_start_o, '0);
      chk("rst_key", core_key_o, '0);
      chk("rst_pt", core_pt_o, '0);
      chk("rst_busy", busy_o, '0);
      chk("rst_grant", grant_id_o, '0);
      chk("rst_ready", req_ready_o, '0);
      last_m = N - 1;
      drv_edge();
   endtask

   // One complete job: acceptance, start pulse, core latency (or stall), response handshake.
   task automatic job(input int lat, input int hold, input bit to, input bit keep,
                      input int max_wait, output int g);
      logic [127:0] ek, ep, ect;
      bit           seen;
      int           w, n_wait;
      g    = -1;
      seen = 1'b0;
      for (int t = 0; t < max_wait && !seen; t++) begin
         @(negedge clk);
         if (t == 0) begin
            chk("idle_busy", busy_o, '0);
            chk("idle_rsp_valid", rsp_valid_o, '0);
         end
         if (req_ready_o != '0) seen = 1'b1;
         else drv_edge();
      end
      chk("accept_seen", seen, 1'b1);
      if (!seen) return;
      w = ref_winner(req_valid_i, last_m);
      chk("grant_onehot", req_ready_o, oh(w));
      g  = w;
      ek = key_a[w];
      ep = pt_a[w];
      drv_edge();
      if (keep) begin
         key_a[w] = rnd128();
         pt_a[w]  = rnd128();
      end else begin
         req_valid_i = req_valid_i & ~oh(w);
      end
      if (flood) req_valid_i = req_valid_i | ~oh(w);
      @(negedge clk);
      chk("issue_start", core_start_o, 1'b1);
      chk("issue_key", core_key_o, ek);
      chk("issue_pt", core_pt_o, ep);
      chk("issue_grant", grant_id_o, 128'(w));
      chk("issue_busy", busy_o, 1'b1);
      chk("issue_no_ready", req_ready_o, '0);
      ect    = (ek == FIPS_KEY && ep == FIPS_PT) ? FIPS_CT : rnd128();
      n_wait = to ? TO : lat;
      for (int k = 0; k < n_wait; k++) begin
         drv_edge();
         core_done_i = !to && (k == lat - 1);
         core_ct_i   = core_done_i ? ect : rnd128();
         @(negedge clk);
         chk("wait_start", core_start_o, 1'b0);
         chk("wait_rsp_valid", rsp_valid_o, '0);
         chk("wait_key", core_key_o, ek);
         chk("wait_pt", core_pt_o, ep);
      end
      for (int h = 0; h <= hold; h++) begin
         drv_edge();
         core_done_i = to && (h == 0);
         core_ct_i   = rnd128();
         rsp_ready_i = (h % 3 == 1) ? ~oh(g) : '0;
         if (h == hold) rsp_ready_i = rsp_ready_i | oh(g);
         @(negedge clk);
         chk("rsp_valid", rsp_valid_o, oh(g));
         chk("rsp_data", rsp_data_o, to ? 128'd0 : ect);
         chk("rsp_err", rsp_err_o, to);
         chk("rsp_no_accept", req_ready_o, '0);
         chk("rsp_busy", busy_o, 1'b1);
      end
      drv_edge();
      rsp_ready_i = '0;
      core_done_i = 1'b0;
      last_m      = g;
   endtask

   initial begin
      int           g;
      logic [N-1:0] m;
      rst          = 1'b1;
      req_valid_i  = '0;
      rsp_ready_i  = '0;
      core_ready_i = 1'b1;
      core_done_i  = 1'b0;
      core_ct_i    = '0;
      flood        = 1'b0;
      last_m       = N - 1;
      for (int i = 0; i < N; i++) begin
         key_a[i] = '0;
         pt_a[i]  = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      apply_reset();

      // single request, FIPS-197 vector
      key_a[2]    = FIPS_KEY;
      pt_a[2]     = FIPS_PT;
      req_valid_i = 4'b0100;
      job(3, 0, 1'b0, 1'b0, 5, g);
      chk("single_grant", g, 128'd2);

      // round-robin with all requesters held valid; first job finishes on the watchdog's last cycle
      apply_reset();
      for (int i = 0; i < N; i++) begin
         key_a[i] = rnd128();
         pt_a[i]  = rnd128();
      end
      req_valid_i = '1;
      for (int j = 0; j < 8; j++) begin
         job((j == 0) ? TO : $urandom_range(1, TO), $urandom_range(0, 2), 1'b0, 1'b1,
             (j == 0) ? 3 : 1, g);
         chk("rr_order", g, 128'(j % N));
      end
      req_valid_i = '0;

      // reset during WAIT abandons the job
      key_a[1]    = rnd128();
      req_valid_i = 4'b0010;
      @(negedge clk);
      chk("mr_accept", req_ready_o, oh(ref_winner(req_valid_i, last_m)));
      drv_edge();
      req_valid_i = '0;
      @(negedge clk);
      chk("mr_start", core_start_o, 1'b1);
      repeat (3) drv_edge();
      apply_reset();
      for (int c = 0; c < 5; c++) begin
         core_done_i = (c == 0);
         core_ct_i   = rnd128();
         @(negedge clk);
         chk("mr_no_rsp", rsp_valid_o, '0);
         chk("mr_idle", busy_o, 1'b0);
         drv_edge();
      end
      core_done_i = 1'b0;
      for (int i = 0; i < N; i++) begin
         key_a[i] = rnd128();
         pt_a[i]  = rnd128();
      end
      req_valid_i = '1;
      job(2, 0, 1'b0, 1'b0, 2, g);
      chk("mr_next_grant", g, 128'd0);
      req_valid_i = '0;

      // response backpressure with other requesters waiting
      req_valid_i = 4'b0010;
      flood       = 1'b1;
      job(2, 20, 1'b0, 1'b0, 3, g);
      chk("bp_grant", g, 128'd1);
      flood       = 1'b0;
      req_valid_i = '0;
      @(negedge clk);
      chk("bp_done_busy", busy_o, 1'b0);
      chk("bp_done_valid", rsp_valid_o, '0);
      drv_edge();

      // core never returns done: error response, late done dropped
      key_a[3]    = rnd128();
      req_valid_i = 4'b1000;
      job(0, 1, 1'b1, 1'b0, 3, g);
      chk("to_grant", g, 128'd3);
      for (int c = 0; c < 3; c++) begin
         core_done_i = 1'b1;
         @(negedge clk);
         chk("to_late_done", rsp_valid_o, '0);
         drv_edge();
      end
      core_done_i = 1'b0;

      // core not ready: nothing accepted; a withdrawn request is skipped
      core_ready_i = 1'b0;
      req_valid_i  = 4'b0110;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("nr_no_ready", req_ready_o, '0);
         chk("nr_no_start", core_start_o, 1'b0);
         chk("nr_idle", busy_o, 1'b0);
         drv_edge();
         if (c == 2) req_valid_i = 4'b0100;
      end
      core_ready_i = 1'b1;
      job(4, 0, 1'b0, 1'b0, 1, g);
      chk("nr_grant", g, 128'd2);

      // randomized traffic against the reference model
      for (int r = 0; r < 24; r++) begin
         m = N'($urandom());
         for (int i = 0; i < N; i++) begin
            if (m[i] && !req_valid_i[i]) begin
               key_a[i] = rnd128();
               pt_a[i]  = rnd128();
            end
         end
         req_valid_i = req_valid_i | m;
         if (req_valid_i == '0) begin
            key_a[0]    = rnd128();
            req_valid_i = 4'b0001;
         end
         if ($urandom_range(0, 2) == 0) begin
            core_ready_i = 1'b0;
            for (int c = 0; c < 2; c++) begin
               @(negedge clk);
               chk("rnd_nr_no_ready", req_ready_o, '0);
               drv_edge();
            end
            core_ready_i = 1'b1;
         end
         job($urandom_range(1, TO), $urandom_range(0, 3), ($urandom_range(0, 5) == 0), 1'b0, 2, g);
      end
      req_valid_i = '0;
      repeat (2) drv_edge();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
